// File: rtl/multi_function_counter.sv
// multi_function_counter: modulus-selectable up/down counter with load, carry/borrow pulse and 2-digit 7-seg scan
module multi_function_counter #(
  parameter int TICK_DIV = 25000,
  parameter int SCAN_DIV = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] data,
  input  logic [1:0] mod_sel,
  input  logic       enable,
  input  logic       load,
  input  logic       dir_sel,
  output logic [6:0] digit,
  output logic [1:0] word,
  output logic       cout
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);
  logic [PW-1:0] r_pre;
  logic [SW-1:0] r_scan;
  logic          r_sel;
  logic [3:0]    r_count;
  logic          r_cout;
  logic          w_tick;
  logic [4:0]    w_mod;
  logic [3:0]    w_max;
  logic [3:0]    w_next;
  logic          w_wrap;
  logic [3:0]    w_val;
  assign w_tick = r_pre == P_LAST;
  assign w_mod  = mod_sel == 2'b00 ? 5'd10 : mod_sel == 2'b01 ? 5'd12 : mod_sel == 2'b10 ? 5'd16 : 5'd6;
  assign w_max  = 4'(w_mod - 5'd1);
  // next count and wrap flag: load beats an enabled tick; an out-of-range count after a modulus change snaps to max on a down tick
  always_comb begin
    w_next = r_count;
    w_wrap = 1'b0;
    if (load) w_next = ({1'b0, data} < w_mod) ? data : 4'd0;
    else if (enable && w_tick) begin
      if (dir_sel) begin
        w_wrap = r_count >= w_max;
        w_next = w_wrap ? 4'd0 : r_count + 4'd1;
      end else begin
        w_wrap = r_count == 4'd0;
        w_next = (w_wrap || {1'b0, r_count} >= w_mod) ? w_max : r_count - 4'd1;
      end
    end
  end
  // prescaler free-runs regardless of enable/load
  always_ff @(posedge clock) begin
    if (reset) r_pre <= '0;
    else r_pre <= w_tick ? '0 : r_pre + PW'(1);
  end
  // count and registered carry/borrow pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= 4'd0;
      r_cout  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_cout  <= w_wrap;
    end
  end
  // display scan: digit select flips each time the scan counter wraps
  always_ff @(posedge clock) begin
    if (reset) begin
      r_scan <= '0;
      r_sel  <= 1'b0;
    end else begin
      r_scan <= (r_scan == S_LAST) ? '0 : r_scan + SW'(1);
      r_sel  <= r_sel ^ (r_scan == S_LAST);
    end
  end
  assign w_val = r_sel ? {3'b000, r_count >= 4'd10} : (r_count >= 4'd10 ? r_count - 4'd10 : r_count);
  assign word  = r_sel ? 2'b10 : 2'b01;
  assign cout  = r_cout;
  // 7-segment decode, active-high, bit0=a .. bit6=g
  always_comb begin
    digit = 7'h00;
    case (w_val)
      4'd0: digit = 7'h3F;
      4'd1: digit = 7'h06;
      4'd2: digit = 7'h5B;
      4'd3: digit = 7'h4F;
      4'd4: digit = 7'h66;
      4'd5: digit = 7'h6D;
      4'd6: digit = 7'h7D;
      4'd7: digit = 7'h07;
      4'd8: digit = 7'h7F;
      4'd9: digit = 7'h6F;
      default: digit = 7'h00;
    endcase
  end
endmodule

// File: tb/tb_multi_function_counter.sv
// tb_multi_function_counter: scoreboard bench for the counter and display scan
module tb_multi_function_counter;
  logic       clock;
  logic       reset;
  logic [3:0] data;
  logic [1:0] mod_sel;
  logic       enable;
  logic       load;
  logic       dir_sel;
  logic [6:0] digit;
  logic [1:0] word;
  logic       cout;
  int vectors = 0;
  int errors = 0;
  int couts;
  logic [9:0] q[$];
  logic [9:0] exp_v;
  logic [6:0] segs[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int mods[4] = '{10, 12, 16, 6};
  int m_pre, m_cnt, m_scan, m_sel, m_cout;
  multi_function_counter #(.TICK_DIV(4), .SCAN_DIV(4)) dut (
    .clock(clock), .reset(reset), .data(data), .mod_sel(mod_sel), .enable(enable),
    .load(load), .dir_sel(dir_sel), .digit(digit), .word(word), .cout(cout)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  // drive one cycle, predict the post-edge outputs, queue them, then wait past the edge
  task automatic step(input logic r, input logic ld, input logic en, input logic dir, input logic [1:0] ms, input logic [3:0] d);
    int m;
    bit tick;
    reset = r; load = ld; enable = en; dir_sel = dir; mod_sel = ms; data = d;
    m = mods[ms];
    tick = (m_pre == 3);
    if (r) begin
      m_pre = 0; m_cnt = 0; m_scan = 0; m_sel = 0; m_cout = 0;
    end else begin
      m_pre = (m_pre + 1) % 4;
      m_cout = 0;
      if (ld) m_cnt = (int'(d) < m) ? int'(d) : 0;
      else if (en && tick) begin
        if (dir) begin
          if (m_cnt >= m - 1) begin m_cnt = 0; m_cout = 1; end
          else m_cnt++;
        end else if (m_cnt == 0) begin m_cnt = m - 1; m_cout = 1; end
        else if (m_cnt >= m) m_cnt = m - 1;
        else m_cnt--;
      end
      if (m_scan == 3) begin m_scan = 0; m_sel ^= 1; end
      else m_scan++;
    end
    q.push_back({(m_sel != 0) ? 2'b10 : 2'b01, segs[(m_sel != 0) ? int'(m_cnt >= 10) : m_cnt % 10], m_cout[0]});
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 18; i++) begin
      step(i < 2, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0);
      exp_v = q.pop_front();
      vectors++;
      if ({word, digit, cout} !== exp_v) begin
        errors++;
        $display("FAIL reset cyc%0d got w=%b d=%h c=%b want w=%b d=%h c=%b", i, word, digit, cout, exp_v[9:8], exp_v[7:1], exp_v[0]);
      end
      if (i == 1) begin
        vectors++;
        if (word !== 2'b01 || digit !== 7'h3F || cout !== 1'b0) begin
          errors++;
          $display("FAIL reset_const got w=%b d=%h c=%b want w=01 d=3f c=0", word, digit, cout);
        end
      end
    end
  endtask
  task automatic test_count_up();
    couts = 0;
    for (int i = 0; i < 45; i++) begin
      step(i == 0, 1'b0, 1'b1, 1'b1, 2'b00, 4'd0);
      exp_v = q.pop_front();
      vectors++;
      if ({word, digit, cout} !== exp_v) begin
        errors++;
        $display("FAIL count_up cyc%0d got w=%b d=%h c=%b want w=%b d=%h c=%b", i, word, digit, cout, exp_v[9:8], exp_v[7:1], exp_v[0]);
      end
      couts += int'(cout);
    end
    vectors++;
    if (couts != 1) begin
      errors++;
      $display("FAIL count_up_cout got %0d pulses want 1", couts);
    end
  endtask
  task automatic test_load_hex();
    couts = 0;
    for (int i = 0; i < 13; i++) begin
      step(1'b0, i == 0, 1'b1, 1'b1, 2'b10, 4'd14);
      exp_v = q.pop_front();
      vectors++;
      if ({word, digit, cout} !== exp_v) begin
        errors++;
        $display("FAIL load_hex cyc%0d got w=%b d=%h c=%b want w=%b d=%h c=%b", i, word, digit, cout, exp_v[9:8], exp_v[7:1], exp_v[0]);
      end
      couts += int'(cout);
    end
    vectors++;
    if (couts != 1) begin
      errors++;
      $display("FAIL load_hex_cout got %0d pulses want 1", couts);
    end
  endtask
  task automatic test_mod6_down();
    couts = 0;
    for (int i = 0; i < 13; i++) begin
      step(1'b0, i == 0, 1'b1, 1'b0, 2'b11, 4'd9);
      exp_v = q.pop_front();
      vectors++;
      if ({word, digit, cout} !== exp_v) begin
        errors++;
        $display("FAIL mod6_down cyc%0d got w=%b d=%h c=%b want w=%b d=%h c=%b", i, word, digit, cout, exp_v[9:8], exp_v[7:1], exp_v[0]);
      end
      couts += int'(cout);
    end
    vectors++;
    if (couts != 1) begin
      errors++;
      $display("FAIL mod6_down_cout got %0d pulses want 1", couts);
    end
  endtask
  task automatic test_enable_hold();
    couts = 0;
    for (int i = 0; i < 28; i++) begin
      step(1'b0, i == 18, i < 8, 1'b1, 2'b00, 4'd7);
      exp_v = q.pop_front();
      vectors++;
      if ({word, digit, cout} !== exp_v) begin
        errors++;
        $display("FAIL enable_hold cyc%0d got w=%b d=%h c=%b want w=%b d=%h c=%b", i, word, digit, cout, exp_v[9:8], exp_v[7:1], exp_v[0]);
      end
      if (i >= 8) couts += int'(cout);
    end
    vectors++;
    if (couts != 0) begin
      errors++;
      $display("FAIL enable_hold_cout got %0d pulses want 0", couts);
    end
  endtask
  task automatic test_mod_change();
    for (int pass = 0; pass < 2; pass++) begin
      couts = 0;
      for (int i = 0; i < 5; i++) begin
        step(1'b0, i == 0, i != 0, pass == 0, (i == 0) ? 2'b10 : 2'b00, 4'd13);
        exp_v = q.pop_front();
        vectors++;
        if ({word, digit, cout} !== exp_v) begin
          errors++;
          $display("FAIL mod_change%0d cyc%0d got w=%b d=%h c=%b want w=%b d=%h c=%b", pass, i, word, digit, cout, exp_v[9:8], exp_v[7:1], exp_v[0]);
        end
        if (i != 0) couts += int'(cout);
      end
      vectors++;
      if (couts != ((pass == 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL mod_change%0d_cout got %0d pulses want %0d", pass, couts, (pass == 0) ? 1 : 0);
      end
    end
    step(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 4'd0);
    exp_v = q.pop_front();
    vectors++;
    if (word !== 2'b01 || digit !== 7'h3F || cout !== 1'b0 || {word, digit, cout} !== exp_v) begin
      errors++;
      $display("FAIL mid_reset got w=%b d=%h c=%b want w=01 d=3f c=0", word, digit, cout);
    end
  endtask
  initial begin
    m_pre = 0; m_cnt = 0; m_scan = 0; m_sel = 0; m_cout = 0;
    test_reset();
    test_count_up();
    test_load_hex();
    test_mod6_down();
    test_enable_hold();
    test_mod_change();
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
